// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// RX_PARITY_EN adds the PARITY state and lengthens the frame by one bit.
package uart_rx_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } rx_state_t;

    // Baud ticks from START entry to the checkstop edge
    localparam int FRAME_TICKS_NOPAR = DEF_OVERSAMPLE / 2 + DEF_DATA_BITS * DEF_OVERSAMPLE + DEF_OVERSAMPLE;
    localparam int FRAME_TICKS_PAR   = FRAME_TICKS_NOPAR + DEF_OVERSAMPLE;
`ifdef RX_PARITY_EN
    localparam int FRAME_TICKS = FRAME_TICKS_PAR;
`else
    localparam int FRAME_TICKS = FRAME_TICKS_NOPAR;
`endif

endpackage

// File: rtl/rx_frame_deserializer_if.sv
// Serial line in, assembled byte and stop-check strobe out.
interface rx_frame_deserializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxin;
    logic                 baudtick;
    logic                 rxsample;
    logic [DATA_BITS-1:0] dout1;
    logic                 checkstop;
    logic                 rxbusy;
    logic                 parityerror;

    modport master (
        output rxin, baudtick,
        input  rxsample, dout1, checkstop, rxbusy, parityerror
    );

    modport slave (
        input  rxin, baudtick,
        output rxsample, dout1, checkstop, rxbusy, parityerror
    );
endinterface

// File: rtl/rx_line_sync.sv
// Purpose: 2-FF synchronizer on the serial line plus falling-edge detect.
// Latency: rxsample lags rxin by 2 clk; rxfall is combinational off the flops.
// Backpressure: none, free-running every clk.
module rx_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic rxin,
    output logic rxsample,
    output logic rxfall
);
    logic sync1;
    logic sync2;
    logic prev;

    // Idle line is high, so all stages reset to 1 to avoid a fake edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= rxin;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rxsample = sync2;
    assign rxfall   = prev & ~sync2;
endmodule

// File: rtl/rx_frame_deserializer.sv
// Purpose: UART RX start qualify + LSB-first shift-in, mid-stop checkstop strobe (RX_PARITY_EN adds parity).
// Latency: checkstop 2-3 clk + FRAME_TICKS baudticks after the line falls; dout1 loads at the last data bit.
// Backpressure: none; baudtick low freezes all counters and holds the state.
module rx_frame_deserializer
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = DEF_DATA_BITS
) (
    input  logic                    clk,
    input  logic                    reset,
    rx_frame_deserializer_if.slave  bus
);
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_BITS - 1);

    rx_state_t            state;
    logic [TICK_W-1:0]    tickcnt;
    logic [BIT_W-1:0]     bitcnt;
    logic [DATA_BITS-2:0] shreg;
    logic [DATA_BITS-1:0] dout1;
    logic [DATA_BITS-1:0] byte_next;
    logic                 checkstop;
    logic                 rxsample;
    logic                 rxfall;
`ifdef RX_PARITY_EN
    logic                 parityerror;
`endif

    rx_line_sync u_line_sync (
        .clk      (clk),
        .reset    (reset),
        .rxin     (bus.rxin),
        .rxsample (rxsample),
        .rxfall   (rxfall)
    );

    // shreg holds the earlier bits; the current sample completes the byte
    assign byte_next = {rxsample, shreg};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tickcnt   <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            dout1     <= '0;
            checkstop <= 1'b0;
`ifdef RX_PARITY_EN
            parityerror <= 1'b0;
`endif
        end else begin
            checkstop <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tickcnt <= '0;
                    if (rxfall) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bus.baudtick) begin
                        if (tickcnt == TICK_MID) begin
                            tickcnt <= '0;
                            bitcnt  <= '0;
                            state   <= rxsample ? ST_IDLE : ST_DATA;
                        end else begin
                            tickcnt <= tickcnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.baudtick) begin
                        if (tickcnt == TICK_END) begin
                            tickcnt <= '0;
                            bitcnt  <= bitcnt + 1'b1;
                            shreg   <= byte_next[DATA_BITS-1:1];
                            if (bitcnt == BIT_LAST) begin
                                dout1 <= byte_next;
`ifdef RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end
                        end else begin
                            tickcnt <= tickcnt + 1'b1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    if (bus.baudtick) begin
                        if (tickcnt == TICK_END) begin
                            tickcnt     <= '0;
                            parityerror <= (^dout1) ^ rxsample;
                            state       <= ST_STOP;
                        end else begin
                            tickcnt <= tickcnt + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    // Framing is left to the downstream checker; only strobe here
                    if (bus.baudtick) begin
                        if (tickcnt == TICK_END) begin
                            tickcnt   <= '0;
                            checkstop <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            tickcnt <= tickcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tickcnt <= '0;
                end
            endcase
        end
    end

    assign bus.rxsample  = rxsample;
    assign bus.dout1     = dout1;
    assign bus.checkstop = checkstop;
    assign bus.rxbusy    = (state != ST_IDLE);
`ifdef RX_PARITY_EN
    assign bus.parityerror = parityerror;
`else
    assign bus.parityerror = 1'b0;
`endif
endmodule

// File: tb/tb_rx_frame_deserializer.sv
// Scoreboard bench for rx_frame_deserializer: one baudtick per clk, frames driven bit by bit.
module tb_rx_frame_deserializer;
    import uart_rx_pkg::*;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FT = OS / 2 + DB * OS + PB * OS + OS;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rx_frame_deserializer_if #(.DATA_BITS(DB)) bus ();

    rx_frame_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [DB-1:0] data; logic rxs; logic par; int start; } exp_t;
    typedef struct { logic [DB-1:0] data; logic rxs; int at; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    int   wide_cnt = 0;
    logic cs_prev  = 1'b0;
    logic [DB-1:0] last_byte;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.checkstop) obs_q.push_back('{bus.dout1, bus.rxsample, cyc});
        if (bus.checkstop && cs_prev) wide_cnt++;
        cs_prev = bus.checkstop;
    end

    task automatic drive_bit(input logic b);
        bus.rxin = b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stopb, input logic parb);
        exp_t e;
        e.data = d; e.rxs = stopb; e.par = parb; e.start = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef RX_PARITY_EN
        drive_bit(parb);
`endif
        drive_bit(stopb);
    endtask

    task automatic test_reset();
        bus.rxin = 1'b1; bus.baudtick = 1'b1; reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.dout1 !== '0)        begin n_bad++; $display("FAIL reset_dout1: got %h want 0", bus.dout1); end
        n_cmp++; if (bus.checkstop !== 1'b0)  begin n_bad++; $display("FAIL reset_checkstop: got %b want 0", bus.checkstop); end
        n_cmp++; if (bus.rxbusy !== 1'b0)     begin n_bad++; $display("FAIL reset_rxbusy: got %b want 0", bus.rxbusy); end
        n_cmp++; if (bus.parityerror !== 1'b0) begin n_bad++; $display("FAIL reset_parityerror: got %b want 0", bus.parityerror); end
        n_cmp++; if (bus.rxsample !== 1'b1)   begin n_bad++; $display("FAIL reset_rxsample: got %b want 1", bus.rxsample); end
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_good_frame();
        exp_t e; obs_t o;
        send_frame(8'h09, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL good_strobe: no checkstop, want byte %h", e.data); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL good_dout1: got %h want %h", o.data, e.data); end
                n_cmp++; if (o.rxs !== e.rxs)   begin n_bad++; $display("FAIL good_rxsample: got %b want %b", o.rxs, e.rxs); end
                n_cmp++; if (o.at - e.start < FT + 2 || o.at - e.start > FT + 3)
                    begin n_bad++; $display("FAIL good_latency: got %0d clk want %0d..%0d", o.at - e.start, FT + 2, FT + 3); end
            end
        end
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL good_extra_strobe: got %0d extra want 0", obs_q.size()); obs_q.delete(); end
        n_cmp++; if (wide_cnt != 0)      begin n_bad++; $display("FAIL good_strobe_width: got %0d wide want 0", wide_cnt); end
        n_cmp++; if (bus.parityerror !== 1'b0) begin n_bad++; $display("FAIL good_parityerror: got %b want 0", bus.parityerror); end
        last_byte = 8'h09;
    endtask

    task automatic test_false_start();
        bus.rxin = 1'b0;
        repeat (3) @(negedge clk);
        bus.rxin = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.rxbusy !== 1'b1) begin n_bad++; $display("FAIL false_busy_high: got %b want 1", bus.rxbusy); end
        repeat (20) @(negedge clk);
        n_cmp++; if (bus.rxbusy !== 1'b0)     begin n_bad++; $display("FAIL false_busy_low: got %b want 0", bus.rxbusy); end
        n_cmp++; if (bus.dout1 !== last_byte) begin n_bad++; $display("FAIL false_dout1: got %h want %h", bus.dout1, last_byte); end
        n_cmp++; if (obs_q.size() != 0)       begin n_bad++; $display("FAIL false_strobe: got %0d want 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t o;
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL b2b_strobe: no checkstop, want byte %h", e.data); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL b2b_dout1: got %h want %h", o.data, e.data); end
                n_cmp++; if (o.rxs !== e.rxs)   begin n_bad++; $display("FAIL b2b_rxsample: got %b want %b", o.rxs, e.rxs); end
                n_cmp++; if (o.at - e.start < FT + 2 || o.at - e.start > FT + 3)
                    begin n_bad++; $display("FAIL b2b_latency: got %0d clk want %0d..%0d", o.at - e.start, FT + 2, FT + 3); end
            end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL b2b_extra_strobe: got %0d want 0", obs_q.size()); obs_q.delete(); end
        last_byte = 8'h3C;
    endtask

    task automatic test_reset_midframe();
        logic [DB-1:0] partial;
        exp_t e; obs_t o;
        partial = 8'hD7;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        bus.rxin = partial[4];
        repeat (OS / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.dout1 !== '0)        begin n_bad++; $display("FAIL midrst_dout1: got %h want 0", bus.dout1); end
        n_cmp++; if (bus.rxbusy !== 1'b0)     begin n_bad++; $display("FAIL midrst_rxbusy: got %b want 0", bus.rxbusy); end
        n_cmp++; if (bus.checkstop !== 1'b0)  begin n_bad++; $display("FAIL midrst_checkstop: got %b want 0", bus.checkstop); end
        n_cmp++; if (bus.parityerror !== 1'b0) begin n_bad++; $display("FAIL midrst_parityerror: got %b want 0", bus.parityerror); end
        n_cmp++; if (bus.rxsample !== 1'b1)   begin n_bad++; $display("FAIL midrst_rxsample: got %b want 1", bus.rxsample); end
        bus.rxin = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL midrst_stray_strobe: got %0d want 0", obs_q.size()); obs_q.delete(); end
        send_frame(8'h5A, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL midrst_strobe: no checkstop, want byte %h", e.data); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL midrst_dout1_after: got %h want %h", o.data, e.data); end
                n_cmp++; if (o.rxs !== e.rxs)   begin n_bad++; $display("FAIL midrst_rxsample_after: got %b want %b", o.rxs, e.rxs); end
            end
        end
        last_byte = 8'h5A;
    endtask

    task automatic test_stuck_stop();
        exp_t e; obs_t o;
        send_frame(8'h81, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL stuck_strobe: no checkstop, want byte %h", e.data); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL stuck_dout1: got %h want %h", o.data, e.data); end
                n_cmp++; if (o.rxs !== e.rxs)   begin n_bad++; $display("FAIL stuck_rxsample: got %b want %b", o.rxs, e.rxs); end
            end
        end
        repeat (40) @(negedge clk);
        n_cmp++; if (bus.rxbusy !== 1'b0) begin n_bad++; $display("FAIL stuck_busy: got %b want 0", bus.rxbusy); end
        n_cmp++; if (obs_q.size() != 0)   begin n_bad++; $display("FAIL stuck_spurious: got %0d want 0", obs_q.size()); obs_q.delete(); end
        bus.rxin = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL stuck_recover_strobe: no checkstop, want byte %h", e.data); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL stuck_recover_dout1: got %h want %h", o.data, e.data); end
            end
        end
        last_byte = 8'h42;
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        exp_t e; obs_t o;
        logic want;
        for (int k = 0; k < 2; k++) begin
            send_frame(8'h09, 1'b1, (k == 0) ? 1'b1 : 1'b0);
            e = exp_q.pop_front();
            want = (^e.data) ^ e.par;
            n_cmp++; if (bus.parityerror !== want) begin n_bad++; $display("FAIL parity_%0d: got %b want %b", k, bus.parityerror, want); end
            n_cmp++;
            if (obs_q.size() == 0) begin n_bad++; $display("FAIL parity_strobe_%0d: no checkstop", k); end
            else begin
                o = obs_q.pop_front();
                n_cmp++; if (o.data !== e.data) begin n_bad++; $display("FAIL parity_dout1_%0d: got %h want %h", k, o.data, e.data); end
            end
        end
    endtask
`endif

    initial begin
        bus.rxin = 1'b1;
        bus.baudtick = 1'b1;
        last_byte = '0;
        $display("frame length %0d baud ticks", FRAME_TICKS);
        test_reset();
        test_good_frame();
        test_false_start();
        test_back_to_back();
        test_reset_midframe();
        test_stuck_stop();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rx_frame_deserializer.md
# rx_frame_deserializer

UART receive front end that sits directly upstream of `stop_bit_checker`. It does three things: synchronizes the serial line, detects and qualifies the start bit, and shifts in 8 data bits LSB-first using a 16x oversampling tick. It then presents the assembled byte on `dout1` and issues a one-cycle `checkstop` strobe at mid-stop-bit, where the stop bit checker samples the line.

## Interface
- `OVERSAMPLE`, default 16: baud ticks per bit. Must be an even value ≥ 4.
- `DATA_BITS`, default 8: data bits per frame. `dout1` width follows this parameter.
- `clk` input 1: system clock. All logic is rising-edge.
- `reset` input 1: asynchronous, active-low reset.
- `rxin` input 1: raw serial line. Idles high.
- `baudtick` input 1: single-`clk` enable pulse at OVERSAMPLE × baud rate.
- `rxsample` output 1: synchronized `rxin`. Wire this to the checker's `rxin`.
- `dout1` output DATA_BITS: last assembled byte.
- `checkstop` output 1: one-cycle strobe at mid-stop-bit.
- `rxbusy` output 1: high whenever the state is not IDLE.
- `parityerror` output 1: even-parity mismatch flag (see Configuration).

## Operation
- Synchronizer: 2-FF synchronizer on `rxin`, plus a delayed copy for edge detection. All three flops reset to 1.
- States: IDLE, START, DATA, PARITY (only when `RX_PARITY_EN` is defined), STOP.
- IDLE:
  - A falling edge on `rxsample` (previous 1, current 0) moves to START.
  - On entry, `tickcnt` is cleared to 0.
- START:
  - `tickcnt` increments on each `baudtick`.
  - At the tick where `tickcnt` == OVERSAMPLE/2−1:
    - If `rxsample` == 0, move to DATA and clear `tickcnt` and `bitcnt`.
    - Otherwise it was a false start; return to IDLE.
- DATA:
  - At the tick where `tickcnt` == OVERSAMPLE−1, shift `rxsample` into the MSB of the shift register (right shift), clear `tickcnt`, and increment `bitcnt`.
  - After bit DATA_BITS−1 is sampled:
    - `dout1` loads the complete byte.
    - Next state is PARITY if enabled, otherwise STOP.
- PARITY: same sample point as DATA. Compares the XOR of the data bits against the sampled bit, then moves to STOP.
- STOP:
  - At the tick where `tickcnt` == OVERSAMPLE−1, assert `checkstop` for exactly one `clk` and return to IDLE.
  - No framing check is done here. Framing is the job of the downstream checker.
- Counting: `tickcnt` is `$clog2(OVERSAMPLE)` bits wide and `bitcnt` is `$clog2(DATA_BITS+1)` bits wide. Counters advance only on `baudtick`. `tickcnt` never wraps silently; every wrap point is an explicit clear.
- Stuck-low stop bit: a low stop bit does not create a falling edge, so IDLE waits until the line returns high and falls again. No spurious frame is started.

## Timing
- Reset values:
  - `dout1` = 0, `checkstop` = 0, `rxbusy` = 0, `parityerror` = 0, `rxsample` = 1.
  - State = IDLE, all counters = 0.
- Edge-detect latency: the falling edge on `rxin` is seen 2–3 `clk` later, because of the synchronizer.
- Frame length in `baudtick`s from START entry to the `checkstop` edge:
  - OVERSAMPLE/2 + DATA_BITS·OVERSAMPLE + OVERSAMPLE.
  - Defaults: 152 without parity, 168 with parity.
- `checkstop` is registered. It is high for the `clk` cycle immediately after the qualifying `baudtick` edge.
- Validity during the strobe:
  - `dout1` and `rxsample` are valid during that cycle.
  - `dout1` holds its value until the last data bit of the next frame.
- Reset asserted mid-frame: immediate return to IDLE and reset values. A partial byte is discarded and `dout1` is cleared.
- `baudtick` low for any number of cycles freezes all counters. The state is held.

## Configuration
- Macro: `RX_PARITY_EN`.
- Defined:
  - The PARITY state is included.
  - `parityerror` updates at the parity sample and holds until the next frame's parity sample.
- Undefined:
  - The PARITY state and its logic are absent.
  - `parityerror` is tied to 0. The port stays present so the interface does not change.

## Structure
- Package `uart_rx_pkg` holds:
  - the `rx_state_t` enum;
  - the default OVERSAMPLE and DATA_BITS localparams;
  - the frame-length constants used by the bench.
- Sub-module `rx_line_sync`: 2-FF synchronizer plus falling-edge detector. Outputs are `rxsample` and `rxfall`.

## Test plan
- Frame 0x09 with a good stop bit, `baudtick` every `clk`: `checkstop` pulses once after 152 ticks; `dout1` = 8'b00001001 and `rxsample` = 1 during the strobe.
- False start (line low for 3 ticks, then high): back to IDLE; no `checkstop`; `rxbusy` falls; `dout1` unchanged.
- Back-to-back frames 0xA5 then 0x3C with one stop bit each: two `checkstop` pulses, with `dout1` = 0xA5 then 0x3C.
- Reset pulled low during data bit 4: all outputs return to reset values at once; the next full frame 0x5A is received correctly.
- Stop bit driven low on frame 0x81: `checkstop` still pulses with `rxsample` = 0 and `dout1` = 0x81; no new frame starts until the line goes high and then falls.
- With `RX_PARITY_EN` defined, frame 0x09 with parity bit 1: `parityerror` = 1 after the parity sample. Repeating with parity bit 0 gives `parityerror` = 0.
